uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 42 ++++
 rtl/uart_fifo.sv | 66 ++++++
 rtl/uart_rx_fifo.sv | 221 ++++++++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the oversampling UART receiver: FSM encoding,
// error flag positions, data-width codes and the majority voter.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        PARITY    = 3'd3,
        STOP1     = 3'd4,
        STOP2     = 3'd5,
        WAIT_HIGH = 3'd6
    } state_t;

    localparam int ERR_PARITY  = 0;
    localparam int ERR_FRAMING = 1;
    localparam int ERR_BREAK   = 2;

    localparam int DATA_W  = 8;
    localparam int ERR_W   = 3;
    localparam int FRAME_W = DATA_W + ERR_W;

    localparam logic [1:0] DBITS_5 = 2'd0;
    localparam logic [1:0] DBITS_6 = 2'd1;
    localparam logic [1:0] DBITS_7 = 2'd2;
    localparam logic [1:0] DBITS_8 = 2'd3;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

    // Index of the last data bit for a given width code.
    function automatic logic [2:0] last_bit_idx(input logic [1:0] dbits);
        case (dbits)
            DBITS_5: return 3'd4;
            DBITS_6: return 3'd5;
            DBITS_7: return 3'd6;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through FIFO; a write into a full FIFO succeeds only when
// a pop happens in the same cycle, otherwise o_overflow pulses.
module uart_fifo #(
    parameter int WIDTH = 11,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_wr_en,
    input  logic [WIDTH-1:0] i_wr_data,
    input  logic             i_rd_en,
    output logic [WIDTH-1:0] o_head,
    output logic             o_valid,
    output logic [AW:0]      o_count,
    output logic             o_overflow
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    logic w_empty;
    logic w_full;
    logic w_do_rd;
    logic w_do_wr;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_do_rd = i_rd_en && !w_empty;
    assign w_do_wr = i_wr_en && (!w_full || w_do_rd);

    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_rd) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_do_wr, w_do_rd})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Memory is not reset, so the head is forced to zero while empty.
    assign o_head     = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_valid    = !w_empty;
    assign o_count    = r_count;
    assign o_overflow = i_wr_en && w_full && !w_do_rd;

endmodule

// File: rtl/uart_rx_fifo.sv
// Oversampling UART receiver with 2-of-3 mid-bit voting, parity/framing/break
// detection and a receive FIFO carrying per-frame error flags.
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE  = 16,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          rx,
    input  logic                          oversample_tick,
    input  logic [1:0]                    cfg_data_bits,
    input  logic                          cfg_parity_en,
    input  logic                          cfg_parity_odd,
    input  logic                          cfg_stop2,
    // rd_valid high means rd_data/rd_err hold the head; rd_en pops it and
    // is ignored while rd_valid is low.
    input  logic                          rd_en,
    output logic [7:0]                    rd_data,
    output logic [2:0]                    rd_err,
    output logic                          rd_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overrun,
    input  logic                          clr_overrun,
    output logic [2:0]                    dbg_state
);

    localparam int CW  = $clog2(OVERSAMPLE);
    localparam int MID = OVERSAMPLE / 2;

    localparam logic [CW-1:0] C_S0   = CW'(MID - 1);
    localparam logic [CW-1:0] C_S1   = CW'(MID);
    localparam logic [CW-1:0] C_S2   = CW'(MID + 1);
    localparam logic [CW-1:0] C_LAST = CW'(OVERSAMPLE - 1);

    logic [SYNC_STAGES-1:0] r_sync;
    state_t                 r_state;
    logic [CW-1:0]          r_cnt;
    logic [2:0]             r_bit_idx;
    logic [2:0]             r_last_idx;
    logic                   r_par_en;
    logic                   r_par_odd;
    logic                   r_stop2;
    logic                   r_s0;
    logic                   r_s1;
    logic [DATA_W-1:0]      r_shift;
    logic                   r_par_bit;
    logic                   r_stop1_bit;
    logic                   r_wr_en;
    logic [FRAME_W-1:0]     r_wr_data;
    logic                   r_overrun;

    logic                   w_rx;
    logic                   w_maj;
    logic                   w_at_s2;
    logic                   w_at_last;
    logic [CW-1:0]          w_cnt_next;
    logic                   w_stop1;
    logic [ERR_W-1:0]       w_err;
    logic [FRAME_W-1:0]     w_frame;
    logic [FRAME_W-1:0]     w_head;
    logic                   w_overflow;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], rx};
        end
    end

    assign w_rx       = r_sync[SYNC_STAGES-1];
    assign w_maj      = maj3(r_s0, r_s1, w_rx);
    assign w_at_s2    = (r_cnt == C_S2);
    assign w_at_last  = (r_cnt == C_LAST);
    assign w_cnt_next = w_at_last ? '0 : r_cnt + CW'(1);

    // In STOP1 the vote in flight is the first stop bit; in STOP2 it was stored.
    assign w_stop1 = (r_state == STOP1) ? w_maj : r_stop1_bit;

    always_comb begin
        w_err              = '0;
        w_err[ERR_PARITY]  = r_par_en && (r_par_bit != ((^r_shift) ^ r_par_odd));
        w_err[ERR_FRAMING] = !w_stop1 || !w_maj;
        w_err[ERR_BREAK]   = (r_shift == '0) && (!r_par_en || !r_par_bit) && !w_stop1;
    end

    assign w_frame = {w_err, r_shift};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_last_idx  <= '0;
            r_par_en    <= 1'b0;
            r_par_odd   <= 1'b0;
            r_stop2     <= 1'b0;
            r_s0        <= 1'b1;
            r_s1        <= 1'b1;
            r_shift     <= '0;
            r_par_bit   <= 1'b0;
            r_stop1_bit <= 1'b1;
            r_wr_en     <= 1'b0;
            r_wr_data   <= '0;
        end else begin
            r_wr_en <= 1'b0;
            if (oversample_tick) begin
                if (r_cnt == C_S0) r_s0 <= w_rx;
                if (r_cnt == C_S1) r_s1 <= w_rx;
                case (r_state)
                    IDLE: begin
                        r_cnt <= '0;
                        if (!w_rx) begin
                            r_state    <= START;
                            r_last_idx <= last_bit_idx(cfg_data_bits);
                            r_par_en   <= cfg_parity_en;
                            r_par_odd  <= cfg_parity_odd;
                            r_stop2    <= cfg_stop2;
                            r_shift    <= '0;
                            r_bit_idx  <= '0;
                            r_par_bit  <= 1'b0;
                        end
                    end
                    START: begin
                        r_cnt <= w_cnt_next;
                        if (w_at_s2 && w_maj) begin
                            r_state <= IDLE;
                            r_cnt   <= '0;
                        end else if (w_at_last) begin
                            r_state <= DATA;
                        end
                    end
                    DATA: begin
                        r_cnt <= w_cnt_next;
                        if (w_at_s2) begin
                            r_shift[r_bit_idx] <= w_maj;
                        end
                        if (w_at_last) begin
                            if (r_bit_idx == r_last_idx) begin
                                r_state <= r_par_en ? PARITY : STOP1;
                            end else begin
                                r_bit_idx <= r_bit_idx + 3'd1;
                            end
                        end
                    end
                    PARITY: begin
                        r_cnt <= w_cnt_next;
                        if (w_at_s2) r_par_bit <= w_maj;
                        if (w_at_last) r_state <= STOP1;
                    end
                    STOP1: begin
                        r_cnt <= w_cnt_next;
                        if (w_at_s2) begin
                            r_stop1_bit <= w_maj;
                            if (!r_stop2) begin
                                r_wr_en   <= 1'b1;
                                r_wr_data <= w_frame;
                                r_state   <= w_maj ? IDLE : WAIT_HIGH;
                                r_cnt     <= '0;
                            end
                        end else if (w_at_last) begin
                            r_state <= STOP2;
                        end
                    end
                    STOP2: begin
                        r_cnt <= w_cnt_next;
                        if (w_at_s2) begin
                            r_wr_en   <= 1'b1;
                            r_wr_data <= w_frame;
                            r_state   <= w_maj ? IDLE : WAIT_HIGH;
                            r_cnt     <= '0;
                        end
                    end
                    WAIT_HIGH: begin
                        r_cnt <= '0;
                        if (w_rx) r_state <= IDLE;
                    end
                    default: begin
                        r_state <= IDLE;
                        r_cnt   <= '0;
                    end
                endcase
            end
        end
    end

    uart_fifo #(
        .WIDTH (FRAME_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .reset      (reset),
        .i_wr_en    (r_wr_en),
        .i_wr_data  (r_wr_data),
        .i_rd_en    (rd_en),
        .o_head     (w_head),
        .o_valid    (rd_valid),
        .o_count    (fifo_count),
        .o_overflow (w_overflow)
    );

    // A fresh drop outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overrun <= 1'b0;
        end else if (w_overflow) begin
            r_overrun <= 1'b1;
        end else if (clr_overrun) begin
            r_overrun <= 1'b0;
        end
    end

    assign rd_data   = w_head[DATA_W-1:0];
    assign rd_err    = w_head[FRAME_W-1:DATA_W];
    assign overrun   = r_overrun;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: frame formats, error flags, glitch/break
// handling, FIFO overflow and mid-frame reset.
module tb_uart_rx_fifo;
  import uart_pkg::*;

  logic       clk;
  logic       reset;
  logic       rx;
  logic       oversample_tick;
  logic [1:0] cfg_data_bits;
  logic       cfg_parity_en;
  logic       cfg_parity_odd;
  logic       cfg_stop2;
  logic       rd_en;
  logic [7:0] rd_data;
  logic [2:0] rd_err;
  logic       rd_valid;
  logic [2:0] fifo_count;
  logic       overrun;
  logic       clr_overrun;
  logic [2:0] dbg_state;

  int errors;
  int checks;
  logic [1:0] tick_div;
  logic [7:0] frame_byte;

  uart_rx_fifo #(
    .OVERSAMPLE  (16),
    .FIFO_DEPTH  (4),
    .SYNC_STAGES (2)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .rx              (rx),
    .oversample_tick (oversample_tick),
    .cfg_data_bits   (cfg_data_bits),
    .cfg_parity_en   (cfg_parity_en),
    .cfg_parity_odd  (cfg_parity_odd),
    .cfg_stop2       (cfg_stop2),
    .rd_en           (rd_en),
    .rd_data         (rd_data),
    .rd_err          (rd_err),
    .rd_valid        (rd_valid),
    .fifo_count      (fifo_count),
    .overrun         (overrun),
    .clr_overrun     (clr_overrun),
    .dbg_state       (dbg_state)
  );

  // clock / reset / tick generation
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    tick_div = 2'd0;
    oversample_tick = 1'b0;
    forever begin
      @(negedge clk);
      tick_div = tick_div + 2'd1;
      oversample_tick = (tick_div == 2'd0);
    end
  end

  // driver tasks
  task automatic wait_ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      while (oversample_tick !== 1'b1) @(posedge clk);
    end
  endtask

  task automatic send_bit(input logic v);
    #1 rx = v;
    wait_ticks(16);
  endtask

  task automatic send_frame(input logic [7:0] d, input int nbits, input logic par_en,
                            input logic par_bit, input logic stop2);
    send_bit(1'b0);
    for (int i = 0; i < nbits; i++) send_bit(d[i]);
    if (par_en) send_bit(par_bit);
    send_bit(1'b1);
    if (stop2) send_bit(1'b1);
    wait_ticks(4);
    @(negedge clk);
  endtask

  task automatic pop();
    @(negedge clk);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
  endtask

  task automatic set_cfg(input logic [1:0] db, input logic pe, input logic po, input logic s2);
    cfg_data_bits  = db;
    cfg_parity_en  = pe;
    cfg_parity_odd = po;
    cfg_stop2      = s2;
  endtask

  // scoreboard check
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b1;
    rx = 1'b1;
    rd_en = 1'b0;
    clr_overrun = 1'b0;
    set_cfg(DBITS_8, 1'b0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    check("reset_valid", 32'(rd_valid), 32'h0);
    check("reset_count", 32'(fifo_count), 32'h0);
    check("reset_overrun", 32'(overrun), 32'h0);
    check("reset_data", 32'(rd_data), 32'h0);
    check("reset_err", 32'(rd_err), 32'h0);
    check("reset_state", 32'(dbg_state), 32'(IDLE));
    reset = 1'b0;
    wait_ticks(4);

    // 8N1 0xA5
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0);
    check("a5_count", 32'(fifo_count), 32'd1);
    check("a5_valid", 32'(rd_valid), 32'h1);
    check("a5_data", 32'(rd_data), 32'hA5);
    check("a5_err", 32'(rd_err), 32'h0);
    pop();
    check("a5_pop_count", 32'(fifo_count), 32'd0);

    // 7E1 0x41 with wrong parity bit (even parity of 0x41 is 0)
    set_cfg(DBITS_7, 1'b1, 1'b0, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0);
    check("7e1_data", 32'(rd_data), 32'h41);
    check("7e1_err", 32'(rd_err), 32'h1);
    pop();

    // 7O1 0x41 with correct odd parity bit 1
    set_cfg(DBITS_7, 1'b1, 1'b1, 1'b0);
    send_frame(8'h41, 7, 1'b1, 1'b1, 1'b0);
    check("7o1_data", 32'(rd_data), 32'h41);
    check("7o1_err", 32'(rd_err), 32'h0);
    pop();

    // 5E2 0x15 (three ones, even parity bit 1)
    set_cfg(DBITS_5, 1'b1, 1'b0, 1'b1);
    send_frame(8'h15, 5, 1'b1, 1'b1, 1'b1);
    check("5e2_data", 32'(rd_data), 32'h15);
    check("5e2_err", 32'(rd_err), 32'h0);
    pop();

    // 6N1 0x2A
    set_cfg(DBITS_6, 1'b0, 1'b0, 1'b0);
    send_frame(8'h2A, 6, 1'b0, 1'b0, 1'b0);
    check("6n1_data", 32'(rd_data), 32'h2A);
    check("6n1_err", 32'(rd_err), 32'h0);
    pop();

    // framing error: 8N1 0x55 with stop bit 0
    set_cfg(DBITS_8, 1'b0, 1'b0, 1'b0);
    frame_byte = 8'h55;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(frame_byte[i]);
    send_bit(1'b0);
    send_bit(1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("frm_data", 32'(rd_data), 32'h55);
    check("frm_err", 32'(rd_err), 32'h2);
    check("frm_state", 32'(dbg_state), 32'(IDLE));
    pop();

    // cfg change mid-frame has no effect on the frame in flight
    frame_byte = 8'h96;
    send_bit(1'b0);
    set_cfg(DBITS_5, 1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 8; i++) send_bit(frame_byte[i]);
    send_bit(1'b1);
    wait_ticks(4);
    @(negedge clk);
    check("cfgmid_count", 32'(fifo_count), 32'd1);
    check("cfgmid_data", 32'(rd_data), 32'h96);
    check("cfgmid_err", 32'(rd_err), 32'h0);
    pop();
    set_cfg(DBITS_8, 1'b0, 1'b0, 1'b0);

    // start-bit glitch
    #1 rx = 1'b0;
    wait_ticks(4);
    #1 rx = 1'b1;
    wait_ticks(20);
    @(negedge clk);
    check("glitch_state", 32'(dbg_state), 32'(IDLE));
    check("glitch_count", 32'(fifo_count), 32'd0);

    // sustained break, 20 bit times
    repeat (20) send_bit(1'b0);
    @(negedge clk);
    check("brk_count", 32'(fifo_count), 32'd1);
    check("brk_data", 32'(rd_data), 32'h00);
    check("brk_err", 32'(rd_err), 32'h6);
    check("brk_state", 32'(dbg_state), 32'(WAIT_HIGH));
    send_bit(1'b1);
    send_bit(1'b1);
    @(negedge clk);
    check("brk_idle_state", 32'(dbg_state), 32'(IDLE));
    check("brk_idle_count", 32'(fifo_count), 32'd1);
    pop();
    check("brk_pop_count", 32'(fifo_count), 32'd0);

    // overflow of a depth-4 FIFO
    for (int i = 1; i <= 5; i++) send_frame(8'(i), 8, 1'b0, 1'b0, 1'b0);
    check("ovf_count", 32'(fifo_count), 32'd4);
    check("ovf_overrun", 32'(overrun), 32'h1);
    for (int i = 1; i <= 4; i++) begin
      check("ovf_read", 32'(rd_data), 32'(i));
      pop();
    end
    check("ovf_empty", 32'(rd_valid), 32'h0);
    pop();
    check("pop_empty_count", 32'(fifo_count), 32'd0);
    check("ovf_sticky", 32'(overrun), 32'h1);
    @(negedge clk);
    clr_overrun = 1'b1;
    @(negedge clk);
    clr_overrun = 1'b0;
    check("ovf_cleared", 32'(overrun), 32'h0);

    // reset in the middle of DATA of 0x3C, with one entry already queued
    send_frame(8'h77, 8, 1'b0, 1'b0, 1'b0);
    check("pre_rst_count", 32'(fifo_count), 32'd1);
    frame_byte = 8'h3C;
    send_bit(1'b0);
    for (int i = 0; i < 3; i++) send_bit(frame_byte[i]);
    #1 reset = 1'b1;
    #2;
    check("rst_valid", 32'(rd_valid), 32'h0);
    check("rst_count", 32'(fifo_count), 32'h0);
    check("rst_overrun", 32'(overrun), 32'h0);
    check("rst_data", 32'(rd_data), 32'h0);
    check("rst_err", 32'(rd_err), 32'h0);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    wait_ticks(4);
    send_frame(8'h5A, 8, 1'b0, 1'b0, 1'b0);
    check("post_rst_count", 32'(fifo_count), 32'd1);
    check("post_rst_data", 32'(rd_data), 32'h5A);
    check("post_rst_err", 32'(rd_err), 32'h0);
    pop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
